// File: rtl/timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped countdown timer: register word
// offsets, CTRL bit positions, mode codes and the FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package timer_pkg;

  // Register word offsets (PrAddr[3:2]).
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE field values. Codes 2 and 3 fall back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// -----------------------------------------------------------------------------
// timer_counter_if
// Peripheral-bus slice seen by the timer after the bridge's address decode.
//   sel    chip select
//   we     write strobe
//   addr   word offset PrAddr[3:2]
//   be     byte enables PrBE
//   wdata  write data PrWD
//   rdata  combinational read data, routed onto PrRD
// master: the bridge / CPU side. slave: the timer.
// -----------------------------------------------------------------------------
interface timer_counter_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output be, output wdata,
                  input rdata);
  modport slave  (input sel, input we, input addr, input be, input wdata,
                  output rdata);
endinterface

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Memory-mapped countdown timer with one-shot (held irq) and auto-reload
// (one-cycle irq pulse) modes.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    timer_counter_if.slave: sel/we/addr/be/wdata in, rdata out
//   irq    interrupt request (irq_flag & IM) to one HWInt line
// Register map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO), 3 reserved.
// -----------------------------------------------------------------------------
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] RST_PRESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  timer_counter_if.slave    bus,
  output logic              irq
);

  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;
  state_e           state_q, state_d;

  logic             wr;
  logic             wr_ctrl;
  logic             wr_preset;
  logic             en;
  logic             reload_mode;
  logic [31:0]      preset_ext;
  logic [31:0]      count_ext;
  logic [31:0]      preset_merged;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  assign wr          = bus.sel && bus.we;
  assign wr_ctrl     = wr && (bus.addr == ADDR_CTRL);
  assign wr_preset   = wr && (bus.addr == ADDR_PRESET);
  assign en          = ctrl_q[CTRL_EN];
  assign reload_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // Zero-extend the CNT_W-wide registers onto the 32-bit bus.
  always_comb begin
    preset_ext = '0;
    count_ext  = '0;
    preset_ext[CNT_W-1:0] = preset_q;
    count_ext[CNT_W-1:0]  = count_q;
  end

  assign preset_merged = byte_merge(preset_ext, bus.wdata, bus.be);

  // FSM next state plus register updates. Software writes are applied last so
  // a CTRL write overrides the hardware EN clear taken in INT.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // PRESET=0 lands here on the first count cycle, so it acts like 1.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        if (en && reload_mode) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          // One-shot (or EN already cleared by software): flag is held.
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl) begin
      if (bus.be[0]) ctrl_d = bus.wdata[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) preset_d = preset_merged[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= RST_PRESET;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      unique case (bus.addr)
        ADDR_CTRL:   bus.rdata = {28'd0, ctrl_q};
        ADDR_PRESET: bus.rdata = preset_ext;
        ADDR_COUNT:  bus.rdata = count_ext;
        default:     bus.rdata = '0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
// Directed bench for timer_counter: a register-access vector table, then
// hand-written sequences for reset, one-shot, auto-reload, masking,
// pause/byte lanes and the INT/CTRL-write collision.
// -----------------------------------------------------------------------------
module tb_timer_counter;

  localparam logic [31:0] RST_P = 32'h0000_0007;

  logic clk;
  logic reset;
  logic irq;

  timer_counter_if bus_if ();

  timer_counter #(
    .CNT_W      (32),
    .RST_PRESET (RST_P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        w_sel;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_data;
    logic        r_sel;
    logic [1:0]  r_addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  int one_cnt[8];
  int ar_cnt[13];
  int ar_irq[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check32(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // Called at a falling edge; reads combinationally, no clock edge consumed.
  task automatic read_check(input logic s, input logic [1:0] a, input logic [31:0] exp,
                            input string name);
    bus_if.sel  = s;
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    #1;
    check32(name, bus_if.rdata, exp);
    bus_if.sel  = 1'b0;
  endtask

  // Called at a falling edge; commits at the next rising edge, returns at the
  // following falling edge.
  task automatic do_write(input logic s, input logic w, input logic [1:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    bus_if.sel   = s;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.be    = b;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.sel = 1'b0;
    bus_if.we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    bus_if.sel   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = 2'd0;
    bus_if.be    = 4'h0;
    bus_if.wdata = 32'h0;

    one_cnt = '{0, 0, 5, 4, 3, 2, 1, 0};
    ar_cnt  = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    ar_irq  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    //            wsel  wwe   waddr be    wdata          rsel  raddr  expected
    vecs[0]  = '{1'b0, 1'b0, 2'd1, 4'hF, 32'h0,         1'b1, 2'd1, RST_P,         "preset_rst"};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 4'hF, 32'hFFFF_FFFF, 1'b1, 2'd1, 32'hFFFF_FFFF, "preset_full"};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 4'h3, 32'hAABB_1234, 1'b1, 2'd1, 32'hFFFF_1234, "preset_be3"};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 4'h4, 32'h0056_0000, 1'b1, 2'd1, 32'hFF56_1234, "preset_be4"};
    vecs[4]  = '{1'b1, 1'b1, 2'd1, 4'h0, 32'h0,         1'b1, 2'd1, 32'hFF56_1234, "preset_be0"};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 4'hF, 32'h0,         1'b1, 2'd1, 32'hFF56_1234, "preset_nosel"};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_1234, 1'b1, 2'd2, 32'h0,         "count_ro"};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 1'b1, 2'd3, 32'h0,         "rsvd"};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 4'hF, 32'hFFFF_FFF6, 1'b1, 2'd0, 32'h6,         "ctrl_bits"};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 4'hE, 32'h0000_000F, 1'b1, 2'd0, 32'h6,         "ctrl_lane0"};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 4'h1, 32'h0,         1'b1, 2'd0, 32'h0,         "ctrl_clear"};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0,         1'b0, 2'd1, 32'h0,         "rdata_nosel"};

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset readback.
    read_check(1'b1, 2'd0, 32'h0, "rst_ctrl");
    read_check(1'b1, 2'd1, RST_P, "rst_preset");
    read_check(1'b1, 2'd2, 32'h0, "rst_count");
    read_check(1'b1, 2'd3, 32'h0, "rst_rsvd");
    check_irq("rst_irq", 1'b0);

    // Register-access table (FSM idle throughout).
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].w_we || vecs[i].w_sel)
        do_write(vecs[i].w_sel, vecs[i].w_we, vecs[i].w_addr, vecs[i].w_be, vecs[i].w_data);
      read_check(vecs[i].r_sel, vecs[i].r_addr, vecs[i].exp, vecs[i].name);
      $display("vec %0d %s done", i, vecs[i].name);
    end

    // Reset mid-count: asynchronous, and no irq afterwards.
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd2);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h9);
    repeat (3) step();
    #2 reset = 1'b0;
    read_check(1'b1, 2'd2, 32'h0, "midrst_count_async");
    check_irq("midrst_irq_async", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step();
    check_irq("midrst_irq_after", 1'b0);
    read_check(1'b1, 2'd0, 32'h0, "midrst_ctrl");
    read_check(1'b1, 2'd1, RST_P, "midrst_preset");
    read_check(1'b1, 2'd2, 32'h0, "midrst_count");
    read_check(1'b1, 2'd3, 32'h0, "midrst_rsvd");
    $display("seq reset_mid_count done");

    // One-shot: PRESET=5, CTRL=0x9 at edge N, irq rises after edge N+7.
    do_reset();
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd5);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h9);
    check_irq("os_irq_n0", 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      read_check(1'b1, 2'd2, 32'(one_cnt[k]), $sformatf("os_count_n%0d", k));
      check_irq($sformatf("os_irq_n%0d", k), (k == 7));
    end
    step();
    read_check(1'b1, 2'd0, 32'h8, "os_ctrl_en_cleared");
    read_check(1'b1, 2'd2, 32'h0, "os_count_zero");
    for (int k = 0; k < 20; k++) begin
      step();
      check_irq($sformatf("os_irq_held%0d", k), 1'b1);
    end
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h8);
    check_irq("os_irq_cleared", 1'b0);
    $display("seq one_shot done");

    // Auto-reload: PRESET=3, CTRL=0xB, one-cycle pulse every 5 cycles.
    do_reset();
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd3);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'hB);
    for (int k = 1; k <= 12; k++) begin
      step();
      read_check(1'b1, 2'd2, 32'(ar_cnt[k]), $sformatf("ar_count_n%0d", k));
      check_irq($sformatf("ar_irq_n%0d", k), ar_irq[k] != 0);
    end
    read_check(1'b1, 2'd0, 32'hB, "ar_ctrl_kept");
    $display("seq auto_reload done");

    // Mask: IM=0 keeps irq low; the later CTRL write clears irq_flag.
    do_reset();
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd2);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_irq($sformatf("mask_irq_n%0d", k), 1'b0);
    end
    read_check(1'b1, 2'd0, 32'h0, "mask_fired_en_cleared");
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h8);
    check_irq("mask_irq_after_im", 1'b0);
    $display("seq mask done");

    // Pause: PRESET write mid-count, EN cleared mid-count, COUNT write ignored.
    do_reset();
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd10);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h1);
    repeat (4) step();
    read_check(1'b1, 2'd2, 32'd8, "pause_count_n4");
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd3);
    read_check(1'b1, 2'd2, 32'd7, "pause_preset_no_disturb");
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h0);
    read_check(1'b1, 2'd2, 32'd6, "pause_count_at_clear");
    repeat (4) step();
    read_check(1'b1, 2'd2, 32'd6, "pause_count_frozen");
    do_write(1'b1, 1'b1, 2'd2, 4'hF, 32'h55);
    read_check(1'b1, 2'd2, 32'd6, "pause_count_write_ignored");
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h1);
    step();
    read_check(1'b1, 2'd2, 32'd6, "pause_reen_load_cycle");
    step();
    read_check(1'b1, 2'd2, 32'd3, "pause_reload_new_preset");
    $display("seq pause done");

    // Collision: CTRL=0x9 written on the INT edge of a one-shot run.
    do_reset();
    do_write(1'b1, 1'b1, 2'd1, 4'hF, 32'd2);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h9);
    repeat (4) step();
    check_irq("coll_irq_at_int", 1'b1);
    do_write(1'b1, 1'b1, 2'd0, 4'hF, 32'h9);
    read_check(1'b1, 2'd0, 32'h9, "coll_ctrl_sw_wins");
    check_irq("coll_irq_cleared", 1'b0);
    step();
    step();
    read_check(1'b1, 2'd2, 32'd2, "coll_restart_count");
    step();
    step();
    check_irq("coll_irq_again", 1'b1);
    $display("seq collision done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
